// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter.
//   op_e    : opcode encoding carried on req_op (2 bits per requester)
//   state_e : arbiter FSM state encoding
//   op_bit  : single-bit evaluation of an opcode, replicated across WIDTH
package logic_unit_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  function automatic logic op_bit(op_e op, logic a, logic b);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Round-robin grant selection.
//   req   : NREQ request bits
//   ptr   : highest-priority index for this decision
//   grant : one-hot grant (zero when no request)
//   idx   : binary index of the granted requester
//   any   : at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Two passes: first the requesters at or above ptr, then wrap to the
  // ones below it. The first hit in that order wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i] && (IW'(i) >= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IW'(i);
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// NREQ requesters share one bitwise logic unit (AND/OR/XOR/NAND).
// One operation is in flight at a time: IDLE grants, EXEC computes,
// RESP presents the result until the consumer takes it.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/req_ready: per-requester handshake (ready one-hot or zero)
//   req_a, req_b       : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_op             : packed opcodes, requester i at [i*2 +: 2]
//   rsp_valid/rsp_ready: result handshake
//   rsp_data, rsp_id   : result and owning requester index
//   busy               : FSM not in IDLE
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IW-1:0]         rsp_id,
  output logic                  busy
);

  state_e                     state;
  logic [IW-1:0]              ptr;
  logic [WIDTH-1:0]           a_cap, b_cap;
  op_e                        op_cap;
  logic [NREQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [NREQ-1:0][1:0]       op_arr;
  logic [NREQ-1:0]            grant;
  logic [IW-1:0]              gidx;
  logic                       gany;
  logic                       accept;
  logic [WIDTH-1:0]           result;

  assign a_arr  = req_a;
  assign b_arr  = req_b;
  assign op_arr = req_op;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Ready is the grant itself, so a grant is always a completed handshake.
  // Held low under reset so nothing looks accepted on a reset edge.
  assign req_ready = (state == S_IDLE && !rst) ? grant : '0;
  assign accept    = (state == S_IDLE) && gany;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign result[i] = op_bit(op_cap, a_cap[i], b_cap[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      busy      <= 1'b0;
      a_cap     <= '0;
      b_cap     <= '0;
      op_cap    <= OP_AND;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_cap  <= a_arr[gidx];
            b_cap  <= b_arr[gidx];
            op_cap <= op_e'(op_arr[gidx]);
            rsp_id <= gidx;
            ptr    <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
            busy   <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data  <= result;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  req_op;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic_unit_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*2 +: 2] = op;
  endtask

  // Inputs change at the falling edge; outputs are checked there too.
  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", rsp_id); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy got %b exp 0", busy); end
    rst = 1'b0; req_valid = 4'b0000;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_idle_ready got %b exp 0000", req_ready); end
  endtask

  task automatic test_basic();
    set_req(0, 8'hF0, 8'h3C, 2'd0);
    req_valid = 4'b0001; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_exec_busy got %b exp 1", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_exec_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 8'h30) begin errors++; $display("FAIL basic_rsp_data got %h exp 30", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_rsp_id got %0d exp 0", rsp_id); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_done_valid got %b exp 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_done_busy got %b exp 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4];
    logic [3:0] exp_r;
    exp_d = '{8'h88, 8'hEE, 8'h66, 8'h77};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 8'hCC, 8'hAA, 2'(i));
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      #1;
      exp_r = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL rr_ready c=%0d got %b exp %b", c, req_ready, exp_r); end
      if (c % 3 == 2) begin
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid c=%0d got %b exp 1", c, rsp_valid); end
        checks++; if (rsp_id !== 2'((c / 3) % 4)) begin errors++; $display("FAIL rr_id c=%0d got %0d exp %0d", c, rsp_id, (c / 3) % 4); end
        checks++; if (rsp_data !== exp_d[(c / 3) % 4]) begin errors++; $display("FAIL rr_data c=%0d got %h exp %h", c, rsp_data, exp_d[(c / 3) % 4]); end
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain_busy got %b exp 0", busy); end
  endtask

  // Entry pointer is 1.
  task automatic test_ptr_wrap();
    set_req(1, 8'h0F, 8'hF0, 2'd1);
    set_req(3, 8'h5A, 8'hF0, 2'd0);
    set_req(0, 8'h33, 8'h0F, 2'd2);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_first_ready got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1001;
    @(negedge clk);
    checks++; if (rsp_data !== 8'hFF || rsp_id !== 2'd1) begin errors++; $display("FAIL wrap_first_rsp got %h/%0d exp ff/1", rsp_data, rsp_id); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_grant3 got %b exp 1000", req_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_data !== 8'h50 || rsp_id !== 2'd3) begin errors++; $display("FAIL wrap_rsp3 got %h/%0d exp 50/3", rsp_data, rsp_id); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant0 got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rsp_data !== 8'h3C || rsp_id !== 2'd0) begin errors++; $display("FAIL wrap_rsp0 got %h/%0d exp 3c/0", rsp_data, rsp_id); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle_busy got %b exp 0", busy); end
  endtask

  // Entry pointer is 1.
  task automatic test_backpressure();
    set_req(1, 8'hAA, 8'hFF, 2'd2);
    req_valid = 4'b0010; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b1101;
    #1;
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL bp_exec got ready %b busy %b exp 0000/1", req_ready, busy); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_id !== 2'd1 || busy !== 1'b1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold k=%0d got v%b d%h id%0d busy%b rdy%b exp v1 d55 id1 busy1 rdy0000", k, rsp_valid, rsp_data, rsp_id, busy, req_ready);
      end
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got v%b busy%b exp 0/0", rsp_valid, busy); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_waiting_grant got %b exp 0100", req_ready); end
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_withdraw got busy%b v%b exp 0/0", busy, rsp_valid); end
  endtask

  // Entry pointer is 2.
  task automatic test_reset_exec();
    set_req(2, 8'h11, 8'h22, 2'd1);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rexec_ready got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rexec_busy got %b exp 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rexec_after_rst got v%b busy%b exp 0/0", rsp_valid, busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_discard got v%b exp 0", rsp_valid); end
    set_req(0, 8'h12, 8'h40, 2'd1);
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rexec_ptr0 got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h52 || rsp_id !== 2'd0) begin errors++; $display("FAIL rexec_rsp got v%b %h/%0d exp 1 52/0", rsp_valid, rsp_data, rsp_id); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rexec_idle got %b exp 0", busy); end
  endtask

  // Entry pointer is 1.
  task automatic test_back_to_back();
    set_req(1, 8'hFF, 8'h0F, 2'd3);
    set_req(2, 8'h00, 8'h81, 2'd1);
    req_valid = 4'b0110; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_ready1 got %b exp 0010", req_ready); end
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (rsp_data !== 8'hF0 || rsp_id !== 2'd1) begin errors++; $display("FAIL b2b_nand got %h/%0d exp f0/1", rsp_data, rsp_id); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL b2b_ready2 got %b exp 0100", req_ready); end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++; if (rsp_data !== 8'h81 || rsp_id !== 2'd2) begin errors++; $display("FAIL b2b_or got %h/%0d exp 81/2", rsp_data, rsp_id); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_ptr_wrap();
    test_backpressure();
    test_reset_exec();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
